// File: rtl/sram_master_switcher.sv
// sram_master_switcher: round-robin owner of one shared SRAM port.
// A debounced key press drains the current master, parks the bus for a
// guard interval, then grants the next master in index order.
module sram_master_switcher #(
  parameter int N_MASTERS       = 4,
  parameter int SEL_W           = 2,
  parameter int ADDR_W          = 18,
  parameter int DATA_W          = 16,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int GUARD_CYCLES    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        key_n,
  input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [N_MASTERS*DATA_W-1:0] m_wdata,
  input  logic [N_MASTERS-1:0]        m_drive,
  input  logic [N_MASTERS-1:0]        m_oe_n,
  input  logic [N_MASTERS-1:0]        m_we_n,
  input  logic [N_MASTERS-1:0]        m_en_n,
  input  logic [N_MASTERS-1:0]        m_busy,
  output logic [DATA_W-1:0]           m_rdata,
  output logic [N_MASTERS-1:0]        m_grant,
  output logic [SEL_W-1:0]            sel,
  output logic                        switching,
  output logic [ADDR_W-1:0]           ram_addr,
  inout  wire  [DATA_W-1:0]           ram_data,
  output logic                        ram_oe_n,
  output logic                        ram_we_n,
  output logic                        ram_en_n
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int GW = $clog2(GUARD_CYCLES + 1);

  typedef enum logic [1:0] {ACTIVE, DRAIN, GUARD} state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic              key_s1_q, key_s2_q, key_db_q, press_q;
  logic [DW-1:0]     dcnt_q;

  // per-master views of the flat input buses
  logic [N_MASTERS-1:0][ADDR_W-1:0] addr_v;
  logic [N_MASTERS-1:0][DATA_W-1:0] wdata_v;
  assign addr_v  = m_addr;
  assign wdata_v = m_wdata;

  // two-flop synchroniser; idles at the released level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
    end else begin
      key_s1_q <= key_n;
      key_s2_q <= key_s1_q;
    end
  end

  // debounce: accept a level after DEBOUNCE_CYCLES identical samples, pulse on accepted press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_db_q <= 1'b1;
      dcnt_q   <= '0;
      press_q  <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (key_s2_q == key_db_q) begin
        dcnt_q <= '0;
      end else if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        key_db_q <= key_s2_q;
        dcnt_q   <= '0;
        press_q  <= ~key_s2_q;
      end else begin
        dcnt_q <= dcnt_q + 1'b1;
      end
    end
  end

  // FSM state register; reset parks the bus and points at master 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= GUARD;
      sel_q   <= '0;
      gcnt_q  <= GW'(GUARD_CYCLES);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gcnt_q  <= gcnt_d;
    end
  end

  // next state: presses only count while ACTIVE; drain waits on busy without timeout
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      ACTIVE: if (press_q) state_d = DRAIN;
      DRAIN: begin
        if (!m_busy[sel_q]) begin
          sel_d   = (sel_q == SEL_W'(N_MASTERS - 1)) ? '0 : sel_q + 1'b1;
          gcnt_d  = GW'(GUARD_CYCLES);
          state_d = GUARD;
        end
      end
      GUARD: begin
        gcnt_d = gcnt_q - 1'b1;
        if (gcnt_q == GW'(1)) state_d = ACTIVE;
      end
      default: state_d = GUARD;
    endcase
  end

  logic granted, drive_en;
  assign granted  = (state_q != GUARD);
  assign drive_en = granted && m_drive[sel_q];

  // bus mux: selected master straight through while granted, parked otherwise
  always_comb begin
    m_grant  = '0;
    ram_addr = '0;
    ram_oe_n = 1'b1;
    ram_we_n = 1'b1;
    ram_en_n = 1'b1;
    if (granted) begin
      m_grant[sel_q] = 1'b1;
      ram_addr       = addr_v[sel_q];
      ram_oe_n       = m_oe_n[sel_q];
      ram_we_n       = m_we_n[sel_q];
      ram_en_n       = m_en_n[sel_q];
    end
  end

  // only the granted master can ever reach the data pins
  assign ram_data  = drive_en ? wdata_v[sel_q] : {DATA_W{1'bz}};
  assign m_rdata   = ram_data;
  assign sel       = sel_q;
  assign switching = (state_q != ACTIVE);

endmodule
